edge_trigger_array: RTL and testbench
=====================================

# edge_trigger_array

Parametrised multi-channel edge detector; the next generation of the single-bit XOR edge trigger. Each channel synchronises an asynchronous input, rejects glitches shorter than a programmable number of cycles, and emits a one-cycle pulse on rising, falling or both edges, selected per channel. Each channel also keeps a sticky event flag and a saturating event counter, so software and upstream logic can poll events that a pulse alone would miss.

## Interface
- `CH`, 4: number of independent channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `FILT_CYCLES`, 1: consecutive cycles a new level must persist to be accepted (≥1; 1 = no filtering).
- `CNT_W`, 8: width of each event counter (≥1).

- `clk`  in  1  single clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `in`  in  CH  asynchronous channel inputs.
- `mode`  in  2*CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
- `out`  out  CH  one-cycle event pulse per channel.
- `sticky`  out  CH  per-channel latched event flag.
- `clr`  in  CH  per-channel sticky clear, level sampled each cycle.
- `cnt_clr`  in  1  clears all event counters.
- `evt_cnt`  out  CH*CNT_W  per-channel saturating event count, channel i at [i*CNT_W +: CNT_W].

## Operation
- Reset (`rstn` low, asynchronous): all synchroniser flops, filtered level `f`, filter counter, `out`, `sticky` and `evt_cnt` are 0.
- Synchroniser: `s` is the last stage of a `SYNC_STAGES`-deep flop chain on `in[i]`.
- Filter: the counter increments on each edge where `s != f`.
  - It resets to 0 on any edge where `s == f`.
  - On the edge where `s != f` for the `FILT_CYCLES`-th consecutive time, `f <= s` and the counter resets to 0.
- Change qualification is decided at the edge where `f` updates:
  - 0→1 qualifies in modes 01 and 11.
  - 1→0 qualifies in modes 10 and 11.
  - Mode 00 never qualifies.
- Event: `out[i] <= qualified` (registered), so every pulse is exactly one cycle wide.
- `f` tracks the input in every mode, including 00. Re-enabling a channel therefore never generates a stale edge.
- Sticky flag: set when `out[i]` is high; cleared when `clr[i]` is high.
  - Set and clear in the same cycle: set wins, flag stays 1.
- Event counter: increments by 1 when `out[i]` is high and saturates at 2^CNT_W−1 (no wrap).
  - `cnt_clr` forces 0.
  - `cnt_clr` and increment in the same cycle: the counter becomes 1.
- Input high at reset release: `f` goes 0→1 after the normal latency and produces a rise event.
- Reset mid-filter or mid-pulse: all state clears immediately. No pulse is emitted on release except per the previous rule.

## Timing
- Let `in[i]` change before capture edge k.
  - `f` updates at edge k+SYNC_STAGES+FILT_CYCLES−1.
  - `out[i]` is high for the one cycle after that edge.
- `sticky` and `evt_cnt` reflect the event one edge after `out[i]` rises.
- Glitch rejection: a level seen at `s` for fewer than `FILT_CYCLES` consecutive edges produces no change in `f` and no event.
- Minimum spacing between events on one channel: `FILT_CYCLES` cycles.
- `mode` is sampled at the edge where `f` updates; it needs no synchroniser.
- `clr` and `cnt_clr` take effect at the next edge.

## Structure
- Package `edge_trig_pkg`:
  - mode constants `MODE_OFF`, `MODE_RISE`, `MODE_FALL`, `MODE_BOTH` (2-bit);
  - a function that returns the qualify decision from mode, old `f` and new `f`.
- Sub-module `edge_trig_chan`: one channel (synchroniser, filter, qualifier, sticky, counter), with parameters `SYNC_STAGES`, `FILT_CYCLES`, `CNT_W`.
- Top level instantiates `CH` copies in a generate loop and packs the outputs.

## Test plan
- Defaults (SYNC=2, FILT=1), mode 11 on ch0. `in[0]` rises before edge 10 → `out[0]` high for the cycle after edge 12; falls before edge 20 → second pulse after edge 22; `evt_cnt[0]`=2; `sticky[0]`=1.
- FILT_CYCLES=3, mode 01:
  - 2-cycle high glitch → no pulse, `evt_cnt`=0.
  - 5-cycle high → one pulse, after edge k+4.
  - The falling edge produces no pulse.
- Mode 10 on ch1 and mode 00 on ch2, same square wave on both. Ch1 pulses only on falls. Ch2 never pulses, and switching ch2 to 11 while the input is high gives no spurious pulse.
- CNT_W=2, 5 rise events → `evt_cnt` saturates at 3. `cnt_clr` asserted in the same cycle as an `out` pulse → counter becomes 1. `clr` asserted coinciding with `out` → `sticky` stays 1; `clr` alone → `sticky` becomes 0.
- Reset scenarios:
  - `rstn` low mid-filter (FILT=3, after 2 cycles) → all outputs 0 immediately, no pulse after release while `in` is low.
  - `in` held high across reset release → exactly one rise pulse at the normal latency.

Source files
------------

// File: rtl/edge_trig_pkg.sv
// Shared mode encodings and the edge-qualification rule for the edge trigger array.
package edge_trig_pkg;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;

   // True when the accepted change from f_old to f_new is an event for this mode.
   function automatic logic qualify(input logic [1:0] mode, input logic f_old, input logic f_new);
      logic rise;
      logic fall;
      rise = !f_old && f_new;
      fall = f_old && !f_new;
      return (rise && (mode == MODE_RISE || mode == MODE_BOTH)) ||
             (fall && (mode == MODE_FALL || mode == MODE_BOTH));
   endfunction

endpackage

// File: rtl/edge_trig_chan.sv
// One channel: synchroniser, persistence filter, edge qualifier, sticky flag and saturating counter.
module edge_trig_chan
   import edge_trig_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_CYCLES = 1,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in,
   input  logic [1:0]       mode,
   input  logic             clr,
   input  logic             cnt_clr,
   output logic             out,
   output logic             sticky,
   output logic [CNT_W-1:0] evt_cnt
);

   localparam int unsigned FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   f_q;
   logic [FW-1:0]          filt_q;
   logic                   s;
   logic                   accept_c;

   assign s        = sync_q[SYNC_STAGES-1];
   assign accept_c = (s != f_q) && (filt_q == FW'(FILT_CYCLES - 1));

   // Synchroniser chain, bit 0 is the first capture stage.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], in};
   end

   // Filter runs in every mode so f never goes stale while a channel is off.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         f_q    <= 1'b0;
         filt_q <= '0;
         out    <= 1'b0;
      end else begin
         out <= accept_c && qualify(mode, f_q, s);
         if (s == f_q) begin
            filt_q <= '0;
         end else if (accept_c) begin
            f_q    <= s;
            filt_q <= '0;
         end else begin
            filt_q <= filt_q + FW'(1);
         end
      end
   end

   // Sticky: a new event beats a simultaneous clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)      sticky <= 1'b0;
      else if (out)   sticky <= 1'b1;
      else if (clr)   sticky <= 1'b0;
   end

   // Counter: a clear coinciding with an event leaves a count of one.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         evt_cnt <= '0;
      end else if (cnt_clr) begin
         evt_cnt <= out ? CNT_W'(1) : '0;
      end else if (out && (evt_cnt != '1)) begin
         evt_cnt <= evt_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/edge_trigger_array.sv
// Multi-channel edge trigger: CH independent channels with packed pulse, sticky and count outputs.
module edge_trigger_array #(
   parameter int unsigned CH          = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_CYCLES = 1,
   parameter int unsigned CNT_W       = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [CH-1:0]       in,
   input  logic [2*CH-1:0]     mode,
   output logic [CH-1:0]       out,
   output logic [CH-1:0]       sticky,
   input  logic [CH-1:0]       clr,
   input  logic                cnt_clr,
   output logic [CH*CNT_W-1:0] evt_cnt
);

   for (genvar i = 0; i < CH; i++) begin : g_chan
      edge_trig_chan #(
         .SYNC_STAGES(SYNC_STAGES),
         .FILT_CYCLES(FILT_CYCLES),
         .CNT_W      (CNT_W)
      ) u_chan (
         .clk    (clk),
         .rstn   (rstn),
         .in     (in[i]),
         .mode   (mode[2*i +: 2]),
         .clr    (clr[i]),
         .cnt_clr(cnt_clr),
         .out    (out[i]),
         .sticky (sticky[i]),
         .evt_cnt(evt_cnt[i*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_edge_trigger_array.sv
// Directed bench for edge_trigger_array: default instance (FILT=1, CNT_W=8) and filtered instance (FILT=3, CNT_W=2).
module tb_edge_trigger_array;

   logic        clk;
   logic        rstn;
   logic [3:0]  a_in, a_clr, a_out, a_sticky;
   logic [7:0]  a_mode;
   logic        a_cc;
   logic [31:0] a_cnt;
   logic [3:0]  b_in, b_clr, b_out, b_sticky;
   logic [7:0]  b_mode;
   logic        b_cc;
   logic [7:0]  b_cnt;

   int total = 0;
   int bad   = 0;

   edge_trigger_array #(.CH(4), .SYNC_STAGES(2), .FILT_CYCLES(1), .CNT_W(8)) dut_a (
      .clk(clk), .rstn(rstn), .in(a_in), .mode(a_mode), .out(a_out), .sticky(a_sticky),
      .clr(a_clr), .cnt_clr(a_cc), .evt_cnt(a_cnt));

   edge_trigger_array #(.CH(4), .SYNC_STAGES(2), .FILT_CYCLES(3), .CNT_W(2)) dut_b (
      .clk(clk), .rstn(rstn), .in(b_in), .mode(b_mode), .out(b_out), .sticky(b_sticky),
      .clr(b_clr), .cnt_clr(b_cc), .evt_cnt(b_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      a_in = '0; a_clr = '0; a_cc = 1'b0; a_mode = 8'b0000_0011;
      b_in = '0; b_clr = '0; b_cc = 1'b0; b_mode = 8'b0000_0101;
      tick(2);
      total++;
      if ({a_out, a_sticky, a_cnt} !== 40'h0) begin
         bad++; $display("FAIL reset_a got=%h want=0", {a_out, a_sticky, a_cnt});
      end
      total++;
      if ({b_out, b_sticky, b_cnt} !== 16'h0) begin
         bad++; $display("FAIL reset_b got=%h want=0", {b_out, b_sticky, b_cnt});
      end
      rstn = 1'b1;
      tick(3);
   endtask

   task automatic test_basic();
      a_in[0] = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         tick(1);
         total++;
         if (a_out[0] !== (t == 3)) begin
            bad++; $display("FAIL basic_rise t=%0d got=%b want=%b", t, a_out[0], (t == 3));
         end
         if (t == 4) begin
            total++;
            if (a_sticky[0] !== 1'b1 || a_cnt[7:0] !== 8'd1) begin
               bad++; $display("FAIL basic_rise_flags sticky=%b cnt=%0d want sticky=1 cnt=1", a_sticky[0], a_cnt[7:0]);
            end
         end
      end
      a_in[0] = 1'b0;
      for (int t = 1; t <= 6; t++) begin
         tick(1);
         total++;
         if (a_out[0] !== (t == 3)) begin
            bad++; $display("FAIL basic_fall t=%0d got=%b want=%b", t, a_out[0], (t == 3));
         end
      end
      total++;
      if (a_cnt[7:0] !== 8'd2 || a_sticky[0] !== 1'b1) begin
         bad++; $display("FAIL basic_count cnt=%0d sticky=%b want cnt=2 sticky=1", a_cnt[7:0], a_sticky[0]);
      end
   endtask

   task automatic test_filter();
      b_in[0] = 1'b1;
      tick(2);
      b_in[0] = 1'b0;
      for (int t = 1; t <= 8; t++) begin
         tick(1);
         total++;
         if (b_out[0] !== 1'b0) begin
            bad++; $display("FAIL glitch t=%0d got=%b want=0", t, b_out[0]);
         end
      end
      total++;
      if (b_cnt[1:0] !== 2'd0 || b_sticky[0] !== 1'b0) begin
         bad++; $display("FAIL glitch_flags cnt=%0d sticky=%b want 0 0", b_cnt[1:0], b_sticky[0]);
      end
      b_in[0] = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         tick(1);
         total++;
         if (b_out[0] !== (t == 5)) begin
            bad++; $display("FAIL filt_pulse t=%0d got=%b want=%b", t, b_out[0], (t == 5));
         end
         if (t == 5) b_in[0] = 1'b0;
      end
      total++;
      if (b_cnt[1:0] !== 2'd1 || b_sticky[0] !== 1'b1) begin
         bad++; $display("FAIL filt_flags cnt=%0d sticky=%b want cnt=1 sticky=1", b_cnt[1:0], b_sticky[0]);
      end
   endtask

   task automatic test_modes();
      a_mode = 8'b0000_1011;
      for (int t = 1; t <= 16; t++) begin
         a_in[1] = ((t - 1) % 8) < 4;
         a_in[2] = ((t - 1) % 8) < 4;
         tick(1);
         total++;
         if (a_out[2:1] !== {1'b0, (t == 7 || t == 15)}) begin
            bad++; $display("FAIL modes t=%0d got=%b want=%b", t, a_out[2:1], {1'b0, (t == 7 || t == 15)});
         end
      end
      total++;
      if (a_cnt[15:8] !== 8'd2 || a_cnt[23:16] !== 8'd0) begin
         bad++; $display("FAIL modes_cnt ch1=%0d ch2=%0d want 2 0", a_cnt[15:8], a_cnt[23:16]);
      end
      a_in[2] = 1'b1;
      tick(6);
      a_mode = 8'b0011_1011;
      for (int t = 1; t <= 6; t++) begin
         tick(1);
         total++;
         if (a_out[2] !== 1'b0) begin
            bad++; $display("FAIL reenable t=%0d got=%b want=0", t, a_out[2]);
         end
      end
      total++;
      if (a_cnt[23:16] !== 8'd0 || a_sticky[2] !== 1'b0) begin
         bad++; $display("FAIL reenable_flags cnt=%0d sticky=%b want 0 0", a_cnt[23:16], a_sticky[2]);
      end
   endtask

   task automatic test_sat();
      for (int e = 0; e < 5; e++) begin
         b_in[1] = 1'b1;
         tick(5);
         b_in[1] = 1'b0;
         tick(5);
      end
      total++;
      if (b_cnt[3:2] !== 2'd3) begin
         bad++; $display("FAIL saturate got=%0d want=3", b_cnt[3:2]);
      end
      b_clr[1] = 1'b1;
      tick(1);
      b_clr[1] = 1'b0;
      total++;
      if (b_sticky[1:0] !== 2'b01) begin
         bad++; $display("FAIL clr_alone sticky=%b want=01", b_sticky[1:0]);
      end
      b_in[1] = 1'b1;
      tick(5);
      total++;
      if (b_out[1] !== 1'b1) begin
         bad++; $display("FAIL coincide_pulse got=%b want=1", b_out[1]);
      end
      b_cc = 1'b1;
      b_clr[1] = 1'b1;
      tick(1);
      b_cc = 1'b0;
      b_clr[1] = 1'b0;
      total++;
      if (b_cnt[3:2] !== 2'd1 || b_sticky[1] !== 1'b1) begin
         bad++; $display("FAIL coincide cnt=%0d sticky=%b want cnt=1 sticky=1", b_cnt[3:2], b_sticky[1]);
      end
      b_in[1] = 1'b0;
      tick(5);
      b_cc = 1'b1;
      tick(1);
      b_cc = 1'b0;
      total++;
      if (b_cnt !== 8'h00) begin
         bad++; $display("FAIL cnt_clr got=%h want=00", b_cnt);
      end
   endtask

   task automatic test_reset_mid();
      b_in[0] = 1'b1;
      tick(4);
      rstn = 1'b0;
      #1;
      total++;
      if ({a_out, a_sticky, a_cnt, b_out, b_sticky, b_cnt} !== 56'h0) begin
         bad++; $display("FAIL reset_mid got=%h want=0", {a_out, a_sticky, a_cnt, b_out, b_sticky, b_cnt});
      end
      b_in[0] = 1'b0;
      a_in = '0;
      tick(2);
      rstn = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick(1);
         total++;
         if ({a_out, b_out} !== 8'h00) begin
            bad++; $display("FAIL reset_mid_release t=%0d got=%b want=0", t, {a_out, b_out});
         end
      end
   endtask

   task automatic test_high_release();
      rstn = 1'b0;
      a_in[0] = 1'b1;
      b_in[0] = 1'b1;
      tick(2);
      rstn = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick(1);
         total++;
         if (a_out[0] !== (t == 3) || b_out[0] !== (t == 5)) begin
            bad++; $display("FAIL high_release t=%0d got a=%b b=%b want a=%b b=%b", t, a_out[0], b_out[0], (t == 3), (t == 5));
         end
      end
      total++;
      if (a_cnt[7:0] !== 8'd1 || b_cnt[1:0] !== 2'd1) begin
         bad++; $display("FAIL high_release_cnt a=%0d b=%0d want 1 1", a_cnt[7:0], b_cnt[1:0]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_filter();
      test_modes();
      test_sat();
      test_reset_mid();
      test_high_release();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
